// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: one instruction in flight, valid/ready to memory and to decode.
// Optional IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_25020047_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        seq_err
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [31:0] Ebreak = 32'h0010_0073;
  // TIMEOUT == 0 still needs a 1-bit counter so the declarations stay legal
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;
  logic            seq_err_q, seq_err_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  // Leave WAIT on the cycle the counter would reach TIMEOUT
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_d    = fault_q;
    seq_err_d  = seq_err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (dnpc_valid) begin
          fetch_pc_d = dnpc;
          if (dnpc[1:0] == 2'b00) begin
            state_d = StReq;
          end else begin
            state_d   = StOut;
            inst_d    = Ebreak;
            inst_pc_d = dnpc;
            fault_d   = 1'b1;
          end
        end
      end
      StReq: begin
        if (req_valid_q && req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (rsp_valid) begin
          state_d   = StOut;
          inst_d    = rsp_err ? Ebreak : rsp_data;
          inst_pc_d = fetch_pc_q;
          fault_d   = rsp_err;
        end else if (timeout_hit) begin
          state_d   = StOut;
          inst_d    = Ebreak;
          inst_pc_d = fetch_pc_q;
          fault_d   = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (inst_valid_q && inst_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A next-PC outside IDLE (including the OUT handshake cycle) is a protocol error
    if (dnpc_valid && (state_q != StIdle)) begin
      seq_err_d = 1'b1;
    end

    req_valid_d  = (state_d == StReq);
    inst_valid_d = (state_d == StOut);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StReq;
      fetch_pc_q   <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
      seq_err_q    <= seq_err_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = fetch_pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;
  assign seq_err    = seq_err_q;

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;
  logic        stall_cycle;

  assign stall_cycle = ((state_q == StReq) && !req_ready) || ((state_q == StWait) && !rsp_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if ((state_q == StOut) && inst_valid_q && inst_ready) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (stall_cycle) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed self-checking bench for ysyx_25020047_ifu (TIMEOUT overridden to 4).
module tb_ysyx_25020047_ifu;

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        dnpc_valid;
  logic [31:0] dnpc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        seq_err;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_25020047_ifu #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .dnpc_valid(dnpc_valid),
    .dnpc      (dnpc),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_fault(inst_fault),
    .seq_err   (seq_err)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake_out();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("out_to_idle", 32'(inst_valid), 32'd0);
  endtask

  // From IDLE: aligned fetch with req_ready held low for 'stall' cycles
  task automatic fetch(input logic [31:0] pc, input int stall, input logic [31:0] data);
    req_ready  = 1'b0;
    dnpc       = pc;
    dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("req_hold_valid", 32'(req_valid), 32'd1);
      check("req_hold_addr", req_addr, pc);
      step();
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = data;
    step();
    rsp_valid = 1'b0;
    check("fetch_inst", inst, data);
    check("fetch_pc", inst_pc, pc);
    handshake_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef IFU_PERF_EN
    logic [31:0] pf0, ps0;
`endif
    rst        = 1'b0;
    dnpc_valid = 1'b0;
    dnpc       = '0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    inst_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(inst_fault), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);

    // 1. first fetch from RESET_PC
    rst       = 1'b1;
    req_ready = 1'b1;
    step();
    check("t1_req_valid", 32'(req_valid), 32'd1);
    check("t1_req_addr", req_addr, 32'h8000_0000);
    step();
    check("t1_req_drop", 32'(req_valid), 32'd0);
    check("t1_no_inst_yet", 32'(inst_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_0413;
    step();
    rsp_valid = 1'b0;
    check("t1_inst_valid", 32'(inst_valid), 32'd1);
    check("t1_inst", inst, 32'h0000_0413);
    check("t1_inst_pc", inst_pc, 32'h8000_0000);
    check("t1_fault", 32'(inst_fault), 32'd0);

    // 2. decode stalls; dnpc arrives in OUT and must be ignored
    repeat (2) step();
    dnpc       = 32'h8000_0004;
    dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0;
    repeat (2) step();
    check("t2_hold_valid", 32'(inst_valid), 32'd1);
    check("t2_hold_inst", inst, 32'h0000_0413);
    check("t2_hold_pc", inst_pc, 32'h8000_0000);
    check("t2_seq_err", 32'(seq_err), 32'd1);
    handshake_out();
    repeat (3) step();
    check("t2_no_req", 32'(req_valid), 32'd0);

    // 3. misaligned dnpc faults without a bus request
    dnpc       = 32'h8000_0006;
    dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0;
    check("t3_no_req", 32'(req_valid), 32'd0);
    check("t3_inst_valid", 32'(inst_valid), 32'd1);
    check("t3_inst", inst, Ebreak);
    check("t3_inst_pc", inst_pc, 32'h8000_0006);
    check("t3_fault", 32'(inst_fault), 32'd1);
    handshake_out();

    // 4a. bus error, minimum latency path
    dnpc       = 32'h8000_0004;
    dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0;
    check("t4a_req_valid", 32'(req_valid), 32'd1);
    check("t4a_req_addr", req_addr, 32'h8000_0004);
    step();
    rsp_valid = 1'b1;
    rsp_err   = 1'b1;
    rsp_data  = 32'hdead_beef;
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    check("t4a_inst_valid", 32'(inst_valid), 32'd1);
    check("t4a_inst", inst, Ebreak);
    check("t4a_inst_pc", inst_pc, 32'h8000_0004);
    check("t4a_fault", 32'(inst_fault), 32'd1);
    handshake_out();

    // 4b. timeout after exactly 4 WAIT cycles
    dnpc       = 32'h8000_0008;
    dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0;
    step();
    req_ready = 1'b0;
    repeat (3) step();
    check("t4b_not_yet", 32'(inst_valid), 32'd0);
    step();
    check("t4b_inst_valid", 32'(inst_valid), 32'd1);
    check("t4b_inst", inst, Ebreak);
    check("t4b_inst_pc", inst_pc, 32'h8000_0008);
    check("t4b_fault", 32'(inst_fault), 32'd1);
    handshake_out();

    // 5. reset during WAIT; late response ignored
    req_ready  = 1'b1;
    dnpc       = 32'h8000_000c;
    dnpc_valid = 1'b1;
    step();
    dnpc_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("t5_rst_req", 32'(req_valid), 32'd0);
    check("t5_rst_seq_err", 32'(seq_err), 32'd0);
    rst       = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h1234_5678;
    step();
    rsp_valid = 1'b0;
    check("t5_rsp_ignored", 32'(inst_valid), 32'd0);
    check("t5_req_valid", 32'(req_valid), 32'd1);
    check("t5_req_addr", req_addr, 32'h8000_0000);
    step();
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    check("t5_inst", inst, 32'h0000_0013);
    check("t5_inst_pc", inst_pc, 32'h8000_0000);
    handshake_out();

    // Request held stable while memory is not ready
    fetch(32'h8000_0010, 2, 32'h0010_0093);

`ifdef IFU_PERF_EN
    // 6. three stalled fetches: 2 REQ stall cycles each, no WAIT stalls
    pf0 = perf_fetch;
    ps0 = perf_stall;
    fetch(32'h8000_0020, 2, 32'h0000_0001);
    fetch(32'h8000_0024, 2, 32'h0000_0002);
    fetch(32'h8000_0028, 2, 32'h0000_0003);
    check("t6_perf_fetch", perf_fetch - pf0, 32'd3);
    check("t6_perf_stall", perf_stall - ps0, 32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
